// File: rtl/msk_tx_pkg.sv
// Shared types and the half-sine pulse table builder for the MSK transmitter.
package msk_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Fixed-point scale for the table builder (2^28) and pi in that scale.
  localparam longint FX_ONE = longint'(1) << 28;
  localparam longint FX_PI  = 64'sd843314857;

  // p[k] = round(amp * sin(pi*k/(2*osf))), clamped to the signed range of wo.
  // Integer Taylor series on the angle folded into [0, pi/2], so elaboration
  // needs no real-number support.
  function automatic int pulse_entry(input int k, input int osf, input int amp,
                                     input int wo);
    longint kk;
    longint x;
    longint term;
    longint sum;
    longint val;
    longint lim;
    kk   = (k > osf) ? longint'(2 * osf - k) : longint'(k);
    x    = (FX_PI * kk) / longint'(2 * osf);
    term = x;
    sum  = x;
    for (int i = 1; i < 8; i++) begin
      term = -((((term * x) / FX_ONE) * x) / FX_ONE) / longint'((2 * i) * (2 * i + 1));
      sum  = sum + term;
    end
    if (sum < 0) sum = 0;
    val = (longint'(amp) * sum + FX_ONE / 2) / FX_ONE;
    lim = (longint'(1) << (wo - 1)) - 1;
    if (val > lim) val = lim;
    return int'(val);
  endfunction

endpackage

// File: rtl/msk_halfsine_rom.sv
// Dual-port registered half-sine pulse ROM (one port per channel).
module msk_halfsine_rom #(
  parameter int OSF = 20,
  parameter int WO  = 16,
  parameter int AMP = 16384,
  parameter int KW  = $clog2(2 * OSF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] idx_i,
  input  logic [KW-1:0] idx_q,
  output logic [WO-1:0] p_i,
  output logic [WO-1:0] p_q
);
  import msk_tx_pkg::*;

  logic [WO-1:0] tab [2*OSF];

  for (genvar g = 0; g < 2 * OSF; g++) begin : g_tab
    localparam int VAL = pulse_entry(g, OSF, AMP, WO);
    assign tab[g] = WO'(VAL);
  end

  // Registered read of both ports.
  // NOTE: only the read registers are reset; the table is constant logic and
  // memory contents never take a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_i <= '0;
      p_q <= '0;
    end else begin
      p_i <= tab[idx_i];
      p_q <= tab[idx_q];
    end
  end

endmodule

// File: rtl/msk_halfsine_tx.sv
// MSK modulator as offset-QPSK with half-sine pulses: even bits on I, odd
// bits on Q, each pulse 2*OSF samples, Q offset by OSF samples.
module msk_halfsine_tx #(
  parameter int OSF = 20,
  parameter int WO  = 16,
  parameter int AMP = 16384
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_i,
  input  logic                 bit_val_i,
  output logic                 bit_rdy_o,
  output logic signed [WO-1:0] i_out,
  output logic signed [WO-1:0] q_out,
  output logic                 iq_val_o
);
  import msk_tx_pkg::*;

  localparam int KW = $clog2(2 * OSF);
  localparam int NW = $clog2(OSF);
  localparam logic [NW-1:0] N_LAST = NW'(OSF - 1);
  localparam logic [KW-1:0] K_LAST = KW'(2 * OSF - 1);

  typedef struct packed {
    logic          active;
    logic          sign;
    logic [KW-1:0] k;
  } chan_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic          parity_q, parity_d;
  logic          rdy_d;
  logic          accept;
  chan_t         i_q, i_d, q_q, q_d;
  logic [WO-1:0] rom_i, rom_q;

  // Advance one channel: load on accept, else step through the pulse and
  // go inactive after its last sample.
  function automatic chan_t chan_next(input chan_t c, input logic ld, input logic b);
    chan_t r;
    r = c;
    if (ld) begin
      r.active = 1'b1;
      r.sign   = b;
      r.k      = '0;
    end else if (c.active) begin
      if (c.k == K_LAST) begin
        r.active = 1'b0;
        r.k      = '0;
      end else begin
        r.k = c.k + KW'(1);
      end
    end
    return r;
  endfunction

  // Next-state logic: FSM, symbol counter, parity and channel trackers.
  // NOTE: every signal gets a default at the top so no path infers a latch.
  always_comb begin
    accept   = bit_val_i & bit_rdy_o;
    state_d  = state_q;
    n_d      = n_q;
    parity_d = parity_q;
    case (state_q)
      ST_IDLE: begin
        parity_d = 1'b0;
        if (accept) begin
          state_d  = ST_RUN;
          n_d      = '0;
          parity_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (n_q == N_LAST) begin
          n_d = '0;
          if (accept) parity_d = ~parity_q;
          else        state_d  = ST_FLUSH;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      ST_FLUSH: begin
        if (n_q == N_LAST) begin
          n_d      = '0;
          parity_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (state_d == ST_IDLE) || ((state_d == ST_RUN) && (n_d == N_LAST));
    i_d   = chan_next(i_q, accept & ~parity_q, bit_i);
    q_d   = chan_next(q_q, accept &  parity_q, bit_i);
  end

  // Control and channel state registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      n_q       <= '0;
      parity_q  <= 1'b0;
      bit_rdy_o <= 1'b0;
      i_q       <= '0;
      q_q       <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      parity_q  <= parity_d;
      bit_rdy_o <= rdy_d;
      i_q       <= i_d;
      q_q       <= q_d;
    end
  end

  // The ROM is addressed with the next index, so its output lines up with
  // the registered channel state and the output stage below stays registered.
  msk_halfsine_rom #(
    .OSF(OSF),
    .WO (WO),
    .AMP(AMP),
    .KW (KW)
  ) u_rom (
    .clk  (clk),
    .rst_n(rst_n),
    .idx_i(i_d.k),
    .idx_q(q_d.k),
    .p_i  (rom_i),
    .p_q  (rom_q)
  );

  // Sign/negation output stage; inactive channels emit zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_out    <= '0;
      q_out    <= '0;
      iq_val_o <= 1'b0;
    end else begin
      i_out    <= i_q.active ? (i_q.sign ? $signed(rom_i) : -$signed(rom_i)) : '0;
      q_out    <= q_q.active ? (q_q.sign ? $signed(rom_q) : -$signed(rom_q)) : '0;
      iq_val_o <= (state_q != ST_IDLE);
    end
  end

endmodule
